data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data and address width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12: number of byte-address bits decoded (2^ADDR_WIDTH bytes).
REQ-003 SHALL have parameter LATENCY, default 2, legal range 1..15: cycles from request accept to response for aligned accesses.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port req_valid, input, 1: request present.
REQ-007 SHALL have port req_ready, output, 1: responder can accept; the Memory stage uses its inverse as a stall.
REQ-008 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-009 SHALL have port req_size, input, 2: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-010 SHALL have port req_unsigned, input, 1: zero-extend loads when 1 (LBU/LHU).
REQ-011 SHALL have port req_addr, input, WIDTH: byte address (ALUResultM).
REQ-012 SHALL have port req_wdata, input, WIDTH: store data, right-aligned (WriteDataM).
REQ-013 SHALL have port resp_valid, output, 1: one-cycle response strobe.
REQ-014 SHALL have port resp_rdata, output, WIDTH: extended load data; 0 for stores and errors.
REQ-015 SHALL have port resp_err, output, 1: misaligned or illegal-size request; valid with resp_valid.

Function
REQ-016 SHALL implement a state machine with states IDLE, BUSY, RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE.
REQ-018 SHALL accept a request on a rising edge where req_valid=1 and req_ready=1, latching all req_* fields.
REQ-019 SHALL flag an error when req_size=11, size=01 with addr[0]=1, or size=10 with addr[1:0]!=00.
REQ-020 SHALL, on an erroneous accept, go IDLE->RESP, assert resp_valid and resp_err in the next cycle, and leave memory unchanged.
REQ-021 SHALL, on an aligned accept in cycle T, assert resp_valid in cycle T+LATENCY; LATENCY=1 goes IDLE->RESP, otherwise IDLE->BUSY with a down-counter loaded with LATENCY-2, and BUSY->RESP when the counter reaches 0.
REQ-022 SHALL commit store bytes, little-endian, on the edge entering RESP: byte lane addr[1:0] for a byte store, lanes addr[1:0] and addr[1:0]+1 for a half store, all 4 lanes for a word store.
REQ-023 SHALL leave all other bytes of the addressed word unmodified.
REQ-024 SHALL, for loads, read on the same edge that a store would commit, and sign-extend byte or half data unless req_unsigned=1.
REQ-025 SHALL decode only req_addr[ADDR_WIDTH-1:0]; higher bits are ignored, so addresses wrap around.
REQ-026 SHALL hold resp_valid for exactly one cycle (RESP->IDLE unconditionally); the consumer has no backpressure.
REQ-027 SHALL return a request accepted in IDLE at the earliest on the cycle after RESP, giving a back-to-back throughput of one request per LATENCY+1 cycles.
REQ-028 SHALL ignore req_* inputs while not in IDLE.

Reset
REQ-029 SHALL, while rst=1, force state IDLE, counter 0, resp_valid=0, resp_err=0 and resp_rdata=0; req_ready=1 from the first cycle after reset.
REQ-030 SHALL, on reset during BUSY, abort the pending access so that no store is committed; a store already committed stays.
REQ-031 SHALL NOT reset memory contents.
REQ-032 SHALL give rst priority over a simultaneous req_valid.

Structure
REQ-033 SHALL place the size encoding enum (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum in the shared package pipeline_pkg.
REQ-034 SHALL place byte-lane enable generation, store-data replication and load extraction/extension in one combinational sub-module, lsu_align.
REQ-035 SHALL implement storage as 4 byte-wide arrays of depth 2^(ADDR_WIDTH-2) inside this module.

Verification
REQ-036 SHALL check: LATENCY=2, SW 0xDEADBEEF to 0x100, then LW 0x100 -> second response rdata=0xDEADBEEF, resp_valid exactly 2 cycles after accept.
REQ-037 SHALL check: word 0x100=0x80FF7F01; LB 0x103 -> 0xFFFFFF80; LBU 0x103 -> 0x00000080; LH 0x102 -> 0xFFFF80FF; LHU 0x100 -> 0x00007F01.
REQ-038 SHALL check: SB 0xAA to 0x101 over 0x11223344 -> LW returns 0x1122AA44; SH 0xBEEF to 0x102 -> 0xBEEFAA44.
REQ-039 SHALL check: LH 0x101 -> resp_err=1 one cycle after accept, rdata=0; SW 0x102 -> resp_err=1 and the memory word is unchanged.
REQ-040 SHALL check: SW 0x55 to 0x200 with rst pulsed in the BUSY cycle -> no response, req_ready=1 after reset, LW 0x200 returns the old value.
REQ-041 SHALL check: ADDR_WIDTH=12, SW 0x12345678 to 0x1004 -> LW 0x0004 returns 0x12345678 (wrap).

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and the alignment rule used to flag bad requests.
package pipeline_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam int CNT_W = 4;

  // Size 11 is illegal; halves need an even address, words a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the data memory: lane enables and replicated store
// data on the way in, lane selection plus sign/zero extension on the way out.
module lsu_align
  import pipeline_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       size,
  input  logic [1:0]       addr_lo,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] wdata,
  input  logic [31:0]      rword,
  output logic [3:0]       be,
  output logic [31:0]      wdata_rep,
  output logic [WIDTH-1:0] rdata
);

  logic [31:0] wd_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign wd_s = 32'(wdata);

  // Pick the addressed byte and half out of the stored word.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    case (addr_lo)
      2'b00:   byte_s = rword[7:0];
      2'b01:   byte_s = rword[15:8];
      2'b10:   byte_s = rword[23:16];
      2'b11:   byte_s = rword[31:24];
      default: byte_s = rword[7:0];
    endcase
    if (addr_lo[1]) begin
      half_s = rword[31:16];
    end else begin
      half_s = rword[15:0];
    end
  end

  // Lane enables, store replication and load extension per access size.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = 32'h0000_0000;
    rdata     = '0;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wd_s[7:0]}};
        if (is_unsigned) begin
          rdata = WIDTH'(byte_s);
        end else begin
          rdata = WIDTH'($signed(byte_s));
        end
      end
      SZ_HALF: begin
        if (addr_lo[1]) begin
          be = 4'b1100;
        end else begin
          be = 4'b0011;
        end
        wdata_rep = {2{wd_s[15:0]}};
        if (is_unsigned) begin
          rdata = WIDTH'(half_s);
        end else begin
          rdata = WIDTH'($signed(half_s));
        end
      end
      SZ_WORD: begin
        be        = 4'b1111;
        wdata_rep = wd_s;
        rdata     = WIDTH'(rword);
      end
      default: begin
        be        = 4'b0000;
        wdata_rep = 32'h0000_0000;
        rdata     = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory for the Memory stage. One request in flight;
// stores commit and loads read on the edge that enters RESP.
module data_mem_responder
  import pipeline_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err
);

  localparam int               DEPTH   = 1 << (ADDR_WIDTH - 2);
  localparam logic [CNT_W-1:0] LAT_M2  = CNT_W'(LATENCY - 2);
  localparam bit               LAT_ONE = (LATENCY == 32'sd1);

  state_e                  state_r, state_nx_s;
  logic [CNT_W-1:0]        cnt_r, cnt_nx_s;
  logic                    ready_r, resp_valid_r, resp_err_r;
  logic [WIDTH-1:0]        resp_rdata_r;

  logic                    lat_we_r, lat_uns_r;
  logic [1:0]              lat_size_r;
  logic [ADDR_WIDTH-1:0]   lat_addr_r;
  logic [WIDTH-1:0]        lat_wdata_r;

  logic                    cur_we_s, cur_uns_s, cur_err_s;
  logic [1:0]              cur_size_s;
  logic [ADDR_WIDTH-1:0]   cur_addr_s;
  logic [WIDTH-1:0]        cur_wdata_s;

  logic [ADDR_WIDTH-3:0]   idx_s;
  logic [31:0]             rword_s, wrep_s;
  logic [3:0]              be_s;
  logic [WIDTH-1:0]        load_s;
  logic                    accept_s, commit_s, unused_addr_s;

  logic [7:0] mem0_r [DEPTH];
  logic [7:0] mem1_r [DEPTH];
  logic [7:0] mem2_r [DEPTH];
  logic [7:0] mem3_r [DEPTH];

  // Upper address bits are deliberately dropped so accesses wrap.
  assign unused_addr_s = ^req_addr[WIDTH-1:ADDR_WIDTH];

  // In IDLE the live request drives the datapath (LATENCY=1 and errors
  // finish on the accept edge); afterwards the latched copy does.
  always_comb begin
    if (state_r == IDLE) begin
      cur_we_s    = req_we;
      cur_size_s  = req_size;
      cur_uns_s   = req_unsigned;
      cur_addr_s  = req_addr[ADDR_WIDTH-1:0];
      cur_wdata_s = req_wdata;
    end else begin
      cur_we_s    = lat_we_r;
      cur_size_s  = lat_size_r;
      cur_uns_s   = lat_uns_r;
      cur_addr_s  = lat_addr_r;
      cur_wdata_s = lat_wdata_r;
    end
    cur_err_s = is_misaligned(cur_size_s, cur_addr_s[1:0]);
  end

  assign idx_s    = cur_addr_s[ADDR_WIDTH-1:2];
  assign rword_s  = {mem3_r[idx_s], mem2_r[idx_s], mem1_r[idx_s], mem0_r[idx_s]};
  assign accept_s = (state_r == IDLE) && req_valid;
  assign commit_s = !rst && (state_nx_s == RESP) && !cur_err_s && cur_we_s;

  lsu_align #(.WIDTH(WIDTH)) u_align (
    .size        (cur_size_s),
    .addr_lo     (cur_addr_s[1:0]),
    .is_unsigned (cur_uns_s),
    .wdata       (cur_wdata_s),
    .rword       (rword_s),
    .be          (be_s),
    .wdata_rep   (wrep_s),
    .rdata       (load_s)
  );

  // Next state and latency counter.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          if (cur_err_s || LAT_ONE) begin
            state_nx_s = RESP;
          end else begin
            state_nx_s = BUSY;
            cnt_nx_s   = LAT_M2;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_nx_s = RESP;
        end else begin
          cnt_nx_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      RESP:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State, request latch and registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      ready_r      <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= '0;
      lat_we_r     <= 1'b0;
      lat_uns_r    <= 1'b0;
      lat_size_r   <= 2'b00;
      lat_addr_r   <= '0;
      lat_wdata_r  <= '0;
    end else begin
      state_r      <= state_nx_s;
      cnt_r        <= cnt_nx_s;
      ready_r      <= (state_nx_s == IDLE);
      resp_valid_r <= (state_nx_s == RESP);
      resp_err_r   <= (state_nx_s == RESP) && cur_err_s;
      if ((state_nx_s == RESP) && !cur_err_s && !cur_we_s) begin
        resp_rdata_r <= load_s;
      end else begin
        resp_rdata_r <= '0;
      end
      if (accept_s) begin
        lat_we_r    <= req_we;
        lat_uns_r   <= req_unsigned;
        lat_size_r  <= req_size;
        lat_addr_r  <= req_addr[ADDR_WIDTH-1:0];
        lat_wdata_r <= req_wdata;
      end
    end
  end

  // Byte-lane writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      if (be_s[0]) mem0_r[idx_s] <= wrep_s[7:0];
      if (be_s[1]) mem1_r[idx_s] <= wrep_s[15:8];
      if (be_s[2]) mem2_r[idx_s] <= wrep_s[23:16];
      if (be_s[3]) mem3_r[idx_s] <= wrep_s[31:24];
    end
  end

  assign req_ready  = ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a byte-array reference model
// predicts each response, a negedge monitor pops and compares.
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          due;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mem_m [0:4095];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  data_mem_responder #(.WIDTH(32), .ADDR_WIDTH(12), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: memory as a plain byte array, little-endian, 4 KiB wrap.
  task automatic model_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic err);
    int a, n;
    logic [31:0] v, mask;
    a   = int'(addr % 32'd4096);
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00);
    rd  = 32'd0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) mem_m[a + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(mem_m[a + i]) << (8 * i));
        if (n < 4 && !uns && v[8*n-1]) begin
          mask = (32'd1 << (8 * n)) - 32'd1;
          v = v | ~mask;
        end
        rd = v;
      end
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input bit expect_resp);
    int n;
    exp_t e;
    logic [31:0] rd;
    logic er;
    n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk("ready_wait", {31'd0, req_ready}, 32'd1);
      return;
    end
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    if (expect_resp) begin
      model_req(we, sz, uns, addr, wd, rd, er);
      e.rd  = rd;
      e.err = er;
      e.due = cyc + (er ? 1 : LAT);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_we       = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
    @(negedge clk);
    chk("ready_low_after_accept", {31'd0, req_ready}, 32'd0);
  endtask

  // Monitor: pop on every response strobe, flag late or spurious ones.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (resp_valid) begin
        if (q.size() == 0) begin
          chk("spurious_resp_valid", {31'd0, resp_valid}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("resp_rdata", resp_rdata, e.rd);
          chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
          chk("resp_cycle", cyc, e.due);
        end
      end else if (q.size() != 0 && cyc > q[0].due) begin
        chk("resp_timeout", {31'd0, resp_valid}, 32'd1);
        void'(q.pop_front());
      end else if (q.size() == 0) begin
        chk("idle_resp_valid", {31'd0, resp_valid}, 32'd0);
      end
    end
  end

  initial begin
    int n;
    logic [31:0] a;
    for (int i = 0; i < 4096; i++) mem_m[i] = 8'h00;

    // Reset behaviour.
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // Word round trip.
    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1);

    // Sign/zero extension.
    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'h80FF7F01, 1'b1);
    issue(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1'b1);
    issue(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1'b1);
    issue(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 1'b1);
    issue(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 1'b1);

    // Partial stores preserve neighbouring lanes.
    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'h11223344, 1'b1);
    issue(1'b1, 2'b00, 1'b0, 32'h101, 32'h000000AA, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1);
    issue(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000BEEF, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1);

    // Misaligned and illegal requests.
    issue(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 1'b1);
    issue(1'b1, 2'b10, 1'b0, 32'h102, 32'hFFFFFFFF, 1'b1);
    issue(1'b1, 2'b11, 1'b0, 32'h100, 32'h12345678, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1);

    // Reset in the BUSY cycle aborts the store.
    issue(1'b1, 2'b10, 1'b0, 32'h200, 32'hCAFEF00D, 1'b1);
    issue(1'b1, 2'b10, 1'b0, 32'h200, 32'h00000055, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_busy_rst", {31'd0, req_ready}, 32'd1);
    issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1'b1);

    // Address wrap.
    issue(1'b1, 2'b10, 1'b0, 32'h1004, 32'h12345678, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h0004, 32'h0, 1'b1);

    // Random traffic in a pre-filled window, with random high address bits.
    for (int i = 0; i < 16; i++) issue(1'b1, 2'b10, 1'b0, 32'h300 + 32'(4 * i), $urandom, 1'b1);
    for (int i = 0; i < 200; i++) begin
      a = ($urandom & 32'hFFFFF000) | (32'h300 + 32'($urandom_range(0, 63)));
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, $urandom, 1'b1);
    end

    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) chk("drain", 32'(q.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
